sr_ff_ctrl: RTL and testbench

- Arbitrated sequencer that shares one sr_ff flag between NUM_REQ requesters.
- Each requester asks for a set or a reset of the flag. The block grants requesters round-robin and drives one clean S or R pulse per grant.
- After the pulse it reads back Q, retries on mismatch, and acknowledges the requester.
- Guarantees the illegal S=R=1 input never reaches the flip-flop.

---
 rtl/sr_ctrl_pkg.sv | 19 +
 rtl/rr_arbiter.sv | 35 +++
 rtl/sr_ff_ctrl.sv | 122 ++++++++++++
 tb/tb_sr_ff_ctrl.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/sr_ctrl_pkg.sv
// Shared encodings for the sr_ff arbitrated sequencer.
package sr_ctrl_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_DRIVE = 2'd1;
  localparam logic [1:0] ST_CHECK = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  localparam logic OP_SET   = 1'b1;
  localparam logic OP_RESET = 1'b0;

  typedef enum logic [1:0] {
    IDLE  = ST_IDLE,
    DRIVE = ST_DRIVE,
    CHECK = ST_CHECK,
    DONE  = ST_DONE
  } state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first set req bit at or after ptr, wrapping.
// Zero latency; no backpressure, grant is valid only while vld is high.
module rr_arbiter #(
  parameter  int NUM_REQ = 4,
  localparam int IW      = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IW-1:0]      ptr,
  output logic [NUM_REQ-1:0] gnt,
  output logic [IW-1:0]      gnt_idx,
  output logic               vld
);

  localparam int SW = IW + 1;

  logic [SW-1:0] pos;

  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    vld     = 1'b0;
    pos     = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      // ptr and i are both below NUM_REQ, so one subtraction wraps the sum
      pos = {1'b0, ptr} + SW'(i);
      if (pos >= SW'(NUM_REQ)) pos = pos - SW'(NUM_REQ);
      if (!vld && req[pos[IW-1:0]]) begin
        vld                = 1'b1;
        gnt_idx            = pos[IW-1:0];
        gnt[pos[IW-1:0]]   = 1'b1;
      end
    end
  end

endmodule

// File: rtl/sr_ff_ctrl.sv
// Round-robin sequencer sharing one sr_ff: drives one S/R pulse per grant, verifies Q, retries, acks.
// Ack 3 cycles after req is seen (+2 per retry); waiting requesters simply hold req.
module sr_ff_ctrl
  import sr_ctrl_pkg::*;
#(
  parameter  int NUM_REQ   = 4,
  parameter  int MAX_RETRY = 2,
  localparam int IW        = $clog2(NUM_REQ)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] req,
  input  logic [NUM_REQ-1:0] op,
  output logic [NUM_REQ-1:0] ack,
  output logic               err,
  output logic               S,
  output logic               R,
  input  logic               Q,
  output logic               busy,
  output logic [IW-1:0]      grant_id
);

  localparam logic [2:0] MAX_R = 3'(MAX_RETRY);

  state_t               state, state_nxt;
  logic [IW-1:0]        rr_ptr, rr_ptr_nxt, grant_id_nxt;
  logic                 lat_op, lat_op_nxt;
  logic [2:0]           retry_cnt, retry_cnt_nxt;
  logic                 s_nxt, r_nxt, err_nxt, busy_nxt;
  logic [NUM_REQ-1:0]   ack_nxt;

  logic [NUM_REQ-1:0]   arb_gnt;
  logic [IW-1:0]        arb_idx;
  logic                 arb_vld;
  logic                 sel_op;

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .req     (req),
    .ptr     (rr_ptr),
    .gnt     (arb_gnt),
    .gnt_idx (arb_idx),
    .vld     (arb_vld)
  );

  assign sel_op = |(op & arb_gnt);

  // Outputs are computed from the next state so S/R and ack are clean registered pulses
  always_comb begin
    state_nxt     = state;
    rr_ptr_nxt    = rr_ptr;
    grant_id_nxt  = grant_id;
    lat_op_nxt    = lat_op;
    retry_cnt_nxt = retry_cnt;
    s_nxt         = 1'b0;
    r_nxt         = 1'b0;
    ack_nxt       = '0;
    err_nxt       = 1'b0;
    case (state)
      IDLE: begin
        if (arb_vld) begin
          grant_id_nxt  = arb_idx;
          lat_op_nxt    = sel_op;
          retry_cnt_nxt = '0;
          state_nxt     = DRIVE;
          s_nxt         = (sel_op == OP_SET);
          r_nxt         = (sel_op == OP_RESET);
        end
      end
      DRIVE: begin
        state_nxt = CHECK;
      end
      CHECK: begin
        if (Q == lat_op) begin
          state_nxt         = DONE;
          ack_nxt[grant_id] = 1'b1;
        end else if (retry_cnt < MAX_R) begin
          retry_cnt_nxt = retry_cnt + 3'd1;
          state_nxt     = DRIVE;
          s_nxt         = (lat_op == OP_SET);
          r_nxt         = (lat_op == OP_RESET);
        end else begin
          state_nxt         = DONE;
          ack_nxt[grant_id] = 1'b1;
          err_nxt           = 1'b1;
        end
      end
      DONE: begin
        state_nxt  = IDLE;
        rr_ptr_nxt = (grant_id == IW'(NUM_REQ - 1)) ? '0 : grant_id + IW'(1);
      end
      default: state_nxt = IDLE;
    endcase
    busy_nxt = (state_nxt != IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      rr_ptr    <= '0;
      grant_id  <= '0;
      lat_op    <= 1'b0;
      retry_cnt <= '0;
      S         <= 1'b0;
      R         <= 1'b0;
      ack       <= '0;
      err       <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state     <= state_nxt;
      rr_ptr    <= rr_ptr_nxt;
      grant_id  <= grant_id_nxt;
      lat_op    <= lat_op_nxt;
      retry_cnt <= retry_cnt_nxt;
      S         <= s_nxt;
      R         <= r_nxt;
      ack       <= ack_nxt;
      err       <= err_nxt;
      busy      <= busy_nxt;
    end
  end

endmodule

// File: tb/tb_sr_ff_ctrl.sv
// Directed bench for sr_ff_ctrl with a behavioural sr_ff closing the Q loop.
module tb_sr_ff_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] req = '0;
  logic [3:0] op  = '0;
  logic [3:0] ack;
  logic       err, S, R, Q, busy;
  logic [1:0] grant_id;
  logic       ff_q;
  logic       tie_low = 1'b0;

  int total = 0;
  int bad   = 0;

  sr_ff_ctrl #(.NUM_REQ(4), .MAX_RETRY(2)) dut (
    .clk      (clk),
    .rst      (rst),
    .req      (req),
    .op       (op),
    .ack      (ack),
    .err      (err),
    .S        (S),
    .R        (R),
    .Q        (Q),
    .busy     (busy),
    .grant_id (grant_id)
  );

  always #5 clk = ~clk;

  assign Q = tie_low ? 1'b0 : ff_q;

  always @(posedge clk or posedge rst) begin
    if (rst)    ff_q <= 1'b0;
    else if (S) ff_q <= 1'b1;
    else if (R) ff_q <= 1'b0;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      chk("s_r_exclusive", {31'b0, S & R}, 32'd0);
      chk("ack_onehot0", {31'b0, $onehot0(ack)}, 32'd1);
    end
  end

  task automatic do_reset();
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Waits (bounded) for the next ack, checks it targets id, then drops that request bit.
  task automatic serve(input int id, input string tag);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (ack == 4'b0 && n < 20);
    chk(tag, {28'b0, ack}, 32'd1 << id);
    chk({tag, "_err"}, {31'b0, err}, 32'd0);
    req[id] = 1'b0;
  endtask

  logic [6:0] s_pat;

  initial begin
    // reset state
    @(negedge clk);
    chk("rst_s", {31'b0, S}, 0);
    chk("rst_r", {31'b0, R}, 0);
    chk("rst_ack", {28'b0, ack}, 0);
    chk("rst_err", {31'b0, err}, 0);
    chk("rst_busy", {31'b0, busy}, 0);
    chk("rst_gid", {30'b0, grant_id}, 0);
    @(negedge clk);
    rst = 1'b0;

    // single set: S for one cycle, ack three cycles after req
    op  = 4'b0001;
    req = 4'b0001;
    @(negedge clk);
    chk("t1_s", {31'b0, S}, 1);
    chk("t1_r", {31'b0, R}, 0);
    chk("t1_busy", {31'b0, busy}, 1);
    chk("t1_gid", {30'b0, grant_id}, 0);
    chk("t1_ack_early", {28'b0, ack}, 0);
    @(negedge clk);
    chk("t1_s_off", {31'b0, S}, 0);
    chk("t1_r_off", {31'b0, R}, 0);
    chk("t1_ack_early2", {28'b0, ack}, 0);
    @(negedge clk);
    chk("t1_ack", {28'b0, ack}, 4'b0001);
    chk("t1_err", {31'b0, err}, 0);
    chk("t1_q", {31'b0, Q}, 1);
    req = 4'b0;
    @(negedge clk);
    chk("t1_ack_clr", {28'b0, ack}, 0);
    chk("t1_idle", {31'b0, busy}, 0);

    // reset from Q=1 via requester 2
    op  = 4'b0000;
    req = 4'b0100;
    @(negedge clk);
    chk("t2_s", {31'b0, S}, 0);
    chk("t2_r", {31'b0, R}, 1);
    chk("t2_gid", {30'b0, grant_id}, 2);
    @(negedge clk);
    chk("t2_r_off", {31'b0, R}, 0);
    @(negedge clk);
    chk("t2_ack", {28'b0, ack}, 4'b0100);
    chk("t2_err", {31'b0, err}, 0);
    chk("t2_gid_done", {30'b0, grant_id}, 2);
    chk("t2_q", {31'b0, Q}, 0);
    req = 4'b0;
    @(negedge clk);

    // round-robin ordering, pointer starts at 0
    do_reset();
    op  = 4'b1111;
    req = 4'b1011;
    serve(0, "t3_a0");
    serve(1, "t3_a1");
    serve(3, "t3_a3");
    // pointer wrapped to 0 after serving 3
    req = 4'b1001;
    serve(0, "t3_b0");
    serve(3, "t3_b3");
    req = 4'b0010;
    serve(1, "t3_c1");
    // pointer now 2: search wraps 3 -> 0
    req = 4'b1001;
    serve(3, "t3_d3");
    serve(0, "t3_d0");
    @(negedge clk);

    // Q stuck low: three S pulses two cycles apart, then ack with err
    tie_low = 1'b1;
    op      = 4'b0010;
    req     = 4'b0010;
    s_pat   = 7'b0010101;
    for (int i = 1; i <= 7; i++) begin
      @(negedge clk);
      chk($sformatf("t4_s%0d", i), {31'b0, S}, {31'b0, s_pat[i-1]});
      chk($sformatf("t4_r%0d", i), {31'b0, R}, 0);
      chk($sformatf("t4_ack%0d", i), {28'b0, ack}, (i == 7) ? 32'd2 : 32'd0);
      chk($sformatf("t4_err%0d", i), {31'b0, err}, (i == 7) ? 32'd1 : 32'd0);
    end
    req     = 4'b0;
    tie_low = 1'b0;
    @(negedge clk);

    // reset during DRIVE abandons the grant; held reqs restart from pointer 0
    op  = 4'b1001;
    req = 4'b1001;
    @(negedge clk);
    chk("t5_gid_pre", {30'b0, grant_id}, 3);
    chk("t5_s_pre", {31'b0, S}, 1);
    #2 rst = 1'b1;
    #1;
    chk("t5_s_rst", {31'b0, S}, 0);
    chk("t5_r_rst", {31'b0, R}, 0);
    chk("t5_busy_rst", {31'b0, busy}, 0);
    chk("t5_ack_rst", {28'b0, ack}, 0);
    chk("t5_gid_rst", {30'b0, grant_id}, 0);
    @(negedge clk);
    chk("t5_ack_hold", {28'b0, ack}, 0);
    rst = 1'b0;
    @(negedge clk);
    chk("t5_gid_post", {30'b0, grant_id}, 0);
    chk("t5_s_post", {31'b0, S}, 1);
    serve(0, "t5_a0");
    serve(3, "t5_a3");
    @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
